spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Serial front-end that feeds the single-port RAM stage. It deserialises 10-bit command/data frames from an SPI master (MOSI, SS_n) into parallel `rx_data` with a one-cycle `rx_valid` strobe. For read transactions it captures the RAM's `tx_data`/`tx_valid` response and serialises it back on MISO. SPI bit rate equals `clk`: one bit per rising edge while SS_n is low.

## Interface
- `FRAME_BITS`, 10: parallel frame width (2-bit command + 8-bit payload).
- `DATA_BITS`, 8: width of the read-back data from the RAM.
- `clk`, input, 1: system clock; also the SPI bit clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `SS_n`, input, 1: slave select, active-low; frames transactions.
- `MOSI`, input, 1: serial data in, MSB first.
- `MISO`, output, 1: serial data out, MSB first; 0 when idle.
- `rx_data`, output, FRAME_BITS: assembled frame, to the RAM `din`.
- `rx_valid`, output, 1: one-cycle strobe qualifying `rx_data`.
- `tx_data`, input, DATA_BITS: read data from the RAM `dout`.
- `tx_valid`, input, 1: qualifies `tx_data`.
- `frame_err`, output, 1: present only with `SPI_SLAVE_FRAME_ERR_EN`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: if SS_n = 0, go to CHK_CMD.
- CHK_CMD: sample MOSI as the direction bit.
  - 0: go to WRITE.
  - 1 with `rd_addr_seen` = 0: go to READ_ADD.
  - 1 with `rd_addr_seen` = 1: go to READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase: shift FRAME_BITS bits from MOSI into the shift register, MSB first. On the last bit:
  - `rx_data` <= {shift[8:0], MOSI}.
  - `rx_valid` <= 1 for one cycle.
- After the receive phase:
  - READ_ADD sets `rd_addr_seen`.
  - WRITE and READ_ADD then ignore MOSI until SS_n = 1.
- READ_DATA transmit phase:
  - Wait for `tx_valid` = 1, with no timeout.
  - On that edge, load `tx_data` into the output shift register.
  - Drive 8 bits on MISO, bit 7 first, one per cycle.
  - After bit 0, MISO returns to 0, `rd_addr_seen` clears, and the block ignores activity until SS_n = 1.
- `tx_valid` is ignored in every state except the READ_DATA wait.
- SS_n = 1 in any state → IDLE on the next edge.
  - Partial receive: discarded, no `rx_valid`.
  - Partial transmit: aborted, MISO = 0.
  - `rd_addr_seen` is unchanged on abort.
- `rx_data` holds its last value between strobes.

## Timing
- Reset values: MISO = 0, `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `rd_addr_seen` = 0, state = IDLE.
- Edge E0: SS_n sampled low → CHK_CMD.
- Edge E1: direction bit sampled.
- Edges E2–E11: frame bits 9..0 sampled. `rx_valid` is high for the cycle after E11.
- `tx_valid` is sampled from E12 onward.
- If `tx_valid` is first seen at edge Et, MISO carries bit 7 after Et and bit 0 after Et+7.
- Minimum frames:
  - Write: 12 cycles with SS_n low.
  - Read-data: 12 cycles, plus the wait for `tx_valid`, plus 8 cycles.
- Reset mid-frame behaves as an SS_n abort, and additionally clears `rd_addr_seen` and all outputs.

## Configuration
- `SPI_SLAVE_FRAME_ERR_EN` defined:
  - Adds the `frame_err` port.
  - `frame_err` pulses for one cycle when SS_n rises before the receive phase completes, or mid-transmit.
- Undefined: no port, no logic; aborts are silent.

## Structure
- Package `spi_slave_pkg` holds:
  - the state enum;
  - the command encodings (W_ADD = 2'b00, W_DATA = 2'b01, R_ADD = 2'b10, R_DATA = 2'b11);
  - the FRAME_BITS and DATA_BITS defaults.
- One sub-module, `spi_miso_serializer`, holds the load/shift register and the bit counter for the 8-bit MISO output.

## Test plan
- Write address: SS_n low, MOSI 0 then 10'b00_0000_0101 → `rx_data` = 10'h005, `rx_valid` high exactly one cycle after the 12th edge.
- Write data: same framing with 10'h1A5 → `rx_data` = 10'h1A5; MISO stays 0 throughout.
- Read address then read data: frame 1'b1 + 10'h205, then 1'b1 + 10'h3FF, then `tx_valid` = 1 with `tx_data` = 8'hC3 → MISO shows 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- Direction bit after a completed read-data: next 1'b1 frame → READ_ADD, because `rd_addr_seen` was cleared.
- Abort: SS_n rises after 5 frame bits → no `rx_valid`, state IDLE; with the macro defined, `frame_err` = 1 for one cycle.
- Reset during the READ_DATA wait, `rst_n` low for one edge → all outputs 0; the next read frame is treated as READ_ADD.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// spi_slave_rx_pkg: shared types, command encodings and width defaults for the SPI receive slice
package spi_slave_pkg;
  localparam int DEF_FRAME_BITS = 10;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {P_RX, P_WAIT, P_TX, P_HOLD} phase_t;
  typedef enum logic [1:0] {W_ADD = 2'b00, W_DATA = 2'b01, R_ADD = 2'b10, R_DATA = 2'b11} cmd_t;
endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus RAM-side frame/read-back bus; frame_err exists only with SPI_SLAVE_FRAME_ERR_EN
interface spi_slave_rx_if
  import spi_slave_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [FRAME_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] tx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err;
  modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid, frame_err);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid, frame_err);
`else
  modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_rx_miso_serializer.sv
// spi_miso_serializer: loads a read-back byte and shifts it out MSB first, low when not transmitting
module spi_miso_serializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] din,
  output logic                 miso,
  output logic                 last
);
  localparam int CW = $clog2(DATA_BITS);
  logic [DATA_BITS-1:0] sreg;
  logic [CW-1:0] cnt;
  logic active;
  assign last = active && cnt == CW'(DATA_BITS - 1);
  assign miso = active & sreg[DATA_BITS-1];
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      active <= 1'b0;
      sreg <= '0;
      cnt <= '0;
    end else if (load) begin
      active <= 1'b1;
      sreg <= din;
      cnt <= '0;
    end else if (active) begin
      active <= !last;
      sreg <= sreg << 1;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave deserialising command frames and serialising RAM read-back on MISO
// Optional SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse on aborted receive/transmit.
module spi_slave_rx
  import spi_slave_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input logic           clk,
  input logic           rst_n,
  spi_slave_rx_if.slave bus
);
  localparam int CW = $clog2(FRAME_BITS);
  state_t state, state_nx;
  phase_t phase, phase_nx;
  logic [CW-1:0] cnt;
  logic [FRAME_BITS-2:0] shift;
  logic rd_addr_seen, in_rx, rx_last, load, last, tx_done;
  assign in_rx = state inside {WRITE, READ_ADD, READ_DATA};
  assign rx_last = in_rx && phase == P_RX && cnt == CW'(FRAME_BITS - 1);
  assign load = !bus.SS_n && state == READ_DATA && phase == P_WAIT && bus.tx_valid;
  assign tx_done = !bus.SS_n && phase == P_TX && last;
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    if (bus.SS_n) begin
      state_nx = IDLE;
      phase_nx = P_RX;
    end else if (state == IDLE) state_nx = CHK_CMD;
    else if (state == CHK_CMD) begin
      state_nx = !bus.MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
      phase_nx = P_RX;
    end else if (rx_last) phase_nx = (state == READ_DATA) ? P_WAIT : P_HOLD;
    else if (load) phase_nx = P_TX;
    else if (tx_done) phase_nx = P_HOLD;
  end
  // shift runs freely; at the last frame bit it holds exactly the preceding bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= P_RX;
      cnt <= '0;
      shift <= '0;
      rd_addr_seen <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      cnt <= (!bus.SS_n && in_rx && phase == P_RX) ? cnt + 1'b1 : '0;
      shift <= {shift[FRAME_BITS-3:0], bus.MOSI};
      bus.rx_valid <= !bus.SS_n && rx_last;
      if (!bus.SS_n && rx_last) bus.rx_data <= {shift, bus.MOSI};
      if (!bus.SS_n && rx_last && state == READ_ADD) rd_addr_seen <= 1'b1;
      else if (tx_done) rd_addr_seen <= 1'b0;
    end
  end
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic abort;
  assign abort = bus.SS_n && (state == CHK_CMD || (in_rx && (phase == P_RX || phase == P_TX)));
  always_ff @(posedge clk) bus.frame_err <= rst_n && abort;
`endif
  spi_miso_serializer #(.DATA_BITS(DATA_BITS)) u_ser (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .clr  (bus.SS_n),
    .din  (bus.tx_data),
    .miso (bus.MISO),
    .last (last)
  );
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed and random SPI traffic checked each cycle against an edge-indexed frame model
module tb_spi_slave_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  spi_slave_rx_if bus ();
  spi_slave_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // model: k counts edges since SS_n was first seen low; frame bits live at k = 2..11
  int k = -1;
  int t_tx = -1;
  bit hist [12];
  bit rd_seen = 0, rd_mode = 0, started = 0;
  logic [7:0] txd = '0;
  logic exp_valid = 0, exp_miso = 0, exp_ferr = 0;
  logic [9:0] exp_data = '0;

  initial forever begin
    @(posedge clk);
    started = 1;
    exp_valid = 0;
    exp_ferr = 0;
    if (!rst_n) begin
      k = -1; t_tx = -1; rd_seen = 0; rd_mode = 0; exp_data = '0; exp_miso = 0;
    end else if (bus.SS_n) begin
      exp_ferr = (k >= 0 && k < 11) || (t_tx >= 0 && k + 1 <= t_tx + 8);
      k = -1; t_tx = -1; rd_mode = 0; exp_miso = 0;
    end else begin
      k++;
      if (k < 12) hist[k] = bus.MOSI;
      if (k == 1) rd_mode = bus.MOSI && rd_seen;
      if (k == 11) begin
        exp_valid = 1;
        exp_data = '0;
        for (int i = 2; i < 12; i++) exp_data = {exp_data[8:0], hist[i]};
        if (hist[1] && !rd_mode) rd_seen = 1;
      end
      if (rd_mode && k >= 12 && t_tx < 0 && bus.tx_valid) begin
        t_tx = k;
        txd = bus.tx_data;
      end
      exp_miso = (t_tx >= 0 && k - t_tx <= 7) ? txd[7-(k-t_tx)] : 1'b0;
      if (t_tx >= 0 && k - t_tx == 8) rd_seen = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("rx_valid", bus.rx_valid, exp_valid);
      chk("rx_data", bus.rx_data, exp_data);
      chk("miso", bus.MISO, exp_miso);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("frame_err", bus.frame_err, exp_ferr);
`endif
    end
  end

  task automatic drive(input bit ss, input bit mosi, input bit tv, input logic [7:0] td);
    bus.SS_n = ss;
    bus.MOSI = mosi;
    bus.tx_valid = tv;
    bus.tx_data = td;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic frame(input bit dir, input logic [9:0] d);
    drive(1'b0, 1'($urandom), 1'b0, 8'($urandom));
    drive(1'b0, dir, 1'b0, 8'($urandom));
    for (int i = 9; i >= 0; i--) drive(1'b0, d[i], 1'b0, 8'($urandom));
  endtask

  task automatic read_back(input logic [7:0] d, input string name);
    logic [7:0] m;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, d);
    for (int i = 0; i < 8; i++) begin
      m[7-i] = bus.MISO;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk(name, m, d);
    chk({name, "_end"}, bus.MISO, 1'b0);
  endtask

  task automatic quiet_miso(input string name);
    repeat (3) begin
      drive(1'b0, 1'($urandom), 1'b1, 8'hFF);
      chk(name, bus.MISO, 1'b0);
    end
  endtask

  initial begin
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_rx_data", bus.rx_data, 10'h000);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_miso", bus.MISO, 1'b0);
    rst_n = 1'b1;
    gap(2);
    frame(1'b0, 10'h005);
    chk("wa_valid", bus.rx_valid, 1'b1);
    chk("wa_data", bus.rx_data, 10'h005);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wa_pulse", bus.rx_valid, 1'b0);
    chk("wa_hold", bus.rx_data, 10'h005);
    gap(2);
    frame(1'b0, 10'h1A5);
    chk("wd_data", bus.rx_data, 10'h1A5);
    quiet_miso("wd_miso");
    gap(2);
    frame(1'b1, 10'h205);
    chk("ra_data", bus.rx_data, 10'h205);
    quiet_miso("ra_miso");
    gap(2);
    frame(1'b1, 10'h3FF);
    chk("rd_data", bus.rx_data, 10'h3FF);
    read_back(8'hC3, "rd_c3");
    gap(2);
    frame(1'b1, 10'h155);
    quiet_miso("ra2_miso");
    gap(2);
    frame(1'b1, 10'h0AA);
    read_back(8'h5A, "rd_5a");
    gap(2);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("abort_valid", bus.rx_valid, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_ferr", bus.frame_err, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("abort_ferr_end", bus.frame_err, 1'b0);
`endif
    gap(2);
    frame(1'b0, 10'h2D2);
    chk("after_abort", bus.rx_data, 10'h2D2);
    gap(2);
    frame(1'b1, 10'h300);
    frame(1'b0, 10'h000);
    gap(2);
    frame(1'b1, 10'h301);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("mid_rst_data", bus.rx_data, 10'h000);
    chk("mid_rst_miso", bus.MISO, 1'b0);
    rst_n = 1'b1;
    gap(2);
    frame(1'b1, 10'h123);
    quiet_miso("post_rst_miso");
    gap(2);
    repeat (80) begin
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        gap(1);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 34)) drive(1'b0, 1'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
      gap($urandom_range(1, 3));
    end
    gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
